// File: rtl/spectrum_peak_detector.sv
// rtl/spectrum_peak_detector.sv - per-frame spectral peak search, threshold count and report
//
// Purpose: consumes the shifted FFT power stream. It counts BIN_NUM accepted bins
// per frame, tracks the strongest bin (earliest bin wins ties), counts bins whose
// power exceeds threshold, and emits a one-cycle report when the frame ends.
//
// Optional feature macro: NOISE_SUM_EN
//   When defined, frame_sum reports the sum of all powers in the frame.
//   When undefined, frame_sum is tied to 0.
//
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   valid_in         sample qualifier; every asserted cycle is accepted
//   power_in         shifted power sample
//   fft_index_in     original FFT index of the sample
//   threshold        detection threshold, compared on every accepted bin
//   peak_valid       one-cycle report strobe
//   peak_power       peak power of the reported frame
//   peak_bin         shifted position of the peak
//   peak_fft_index   FFT index captured with the peak
//   det_count        bins above threshold in the reported frame
//   frame_sum        frame power sum (NOISE_SUM_EN only, otherwise 0)
//   busy             high while a frame is partially received
module spectrum_peak_detector #(
  parameter int BIN_NUM = 8000,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 13,
  parameter int SUM_W   = 45
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] power_in,
  input  logic [IDX_W-1:0]  fft_index_in,
  input  logic [DATA_W-1:0] threshold,
  output logic              peak_valid,
  output logic [DATA_W-1:0] peak_power,
  output logic [IDX_W-1:0]  peak_bin,
  output logic [IDX_W-1:0]  peak_fft_index,
  output logic [IDX_W:0]    det_count,
  output logic [SUM_W-1:0]  frame_sum,
  output logic              busy
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(BIN_NUM - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  bin_cnt_q, bin_cnt_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [IDX_W-1:0]  max_bin_q, max_bin_d;
  logic [IDX_W-1:0]  max_idx_q, max_idx_d;
  logic [IDX_W:0]    det_q, det_d;

  logic              peak_valid_q, peak_valid_d;
  logic [DATA_W-1:0] peak_power_q, peak_power_d;
  logic [IDX_W-1:0]  peak_bin_q, peak_bin_d;
  logic [IDX_W-1:0]  peak_idx_q, peak_idx_d;
  logic [IDX_W:0]    det_count_q, det_count_d;

  logic first_bin;
  logic last_bin;
  logic above_thr;

  // In IDLE the bin counter is always 0, so the next accepted sample is bin 0.
  assign first_bin = (state_q == IDLE);
  assign last_bin  = (bin_cnt_q == LAST_BIN);
  assign above_thr = (power_in > threshold);

  always_comb begin
    state_d      = state_q;
    bin_cnt_d    = bin_cnt_q;
    max_d        = max_q;
    max_bin_d    = max_bin_q;
    max_idx_d    = max_idx_q;
    det_d        = det_q;
    peak_valid_d = 1'b0;
    peak_power_d = peak_power_q;
    peak_bin_d   = peak_bin_q;
    peak_idx_d   = peak_idx_q;
    det_count_d  = det_count_q;

    if (valid_in) begin
      if (first_bin) begin
        state_d   = SCAN;
        max_d     = power_in;
        max_bin_d = '0;
        max_idx_d = fft_index_in;
        det_d     = {{IDX_W{1'b0}}, above_thr};
      end else begin
        // Strict compare keeps the earliest bin on ties.
        if (power_in > max_q) begin
          max_d     = power_in;
          max_bin_d = bin_cnt_q;
          max_idx_d = fft_index_in;
        end
        det_d = det_q + {{IDX_W{1'b0}}, above_thr};
      end

      if (last_bin) begin
        // The last sample is already folded into the *_d values, so the report
        // loads from them on the same edge. Returning to IDLE lets a sample in
        // the very next cycle start the following frame without a bubble.
        state_d      = IDLE;
        bin_cnt_d    = '0;
        peak_valid_d = 1'b1;
        peak_power_d = max_d;
        peak_bin_d   = max_bin_d;
        peak_idx_d   = max_idx_d;
        det_count_d  = det_d;
      end else begin
        bin_cnt_d = bin_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bin_cnt_q    <= '0;
      max_q        <= '0;
      max_bin_q    <= '0;
      max_idx_q    <= '0;
      det_q        <= '0;
      peak_valid_q <= 1'b0;
      peak_power_q <= '0;
      peak_bin_q   <= '0;
      peak_idx_q   <= '0;
      det_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      bin_cnt_q    <= bin_cnt_d;
      max_q        <= max_d;
      max_bin_q    <= max_bin_d;
      max_idx_q    <= max_idx_d;
      det_q        <= det_d;
      peak_valid_q <= peak_valid_d;
      peak_power_q <= peak_power_d;
      peak_bin_q   <= peak_bin_d;
      peak_idx_q   <= peak_idx_d;
      det_count_q  <= det_count_d;
    end
  end

`ifdef NOISE_SUM_EN
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [SUM_W-1:0] frame_sum_q, frame_sum_d;

  always_comb begin
    sum_d       = sum_q;
    frame_sum_d = frame_sum_q;
    if (valid_in) begin
      sum_d = first_bin ? SUM_W'(power_in) : sum_q + SUM_W'(power_in);
      if (last_bin) begin
        frame_sum_d = sum_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= '0;
      frame_sum_q <= '0;
    end else begin
      sum_q       <= sum_d;
      frame_sum_q <= frame_sum_d;
    end
  end

  assign frame_sum = frame_sum_q;
`else
  assign frame_sum = '0;
`endif

  assign peak_valid     = peak_valid_q;
  assign peak_power     = peak_power_q;
  assign peak_bin       = peak_bin_q;
  assign peak_fft_index = peak_idx_q;
  assign det_count      = det_count_q;
  assign busy           = (bin_cnt_q != '0) || (state_q == SCAN);

endmodule

// File: tb/tb_spectrum_peak_detector.sv
// tb/tb_spectrum_peak_detector.sv - directed self-checking bench for spectrum_peak_detector
module tb_spectrum_peak_detector;
  localparam int BIN_NUM = 8000;
  localparam int DATA_W  = 32;
  localparam int IDX_W   = 13;
  localparam int SUM_W   = 45;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_in;
  logic [DATA_W-1:0] power_in;
  logic [IDX_W-1:0]  fft_index_in;
  logic [DATA_W-1:0] threshold;
  logic              peak_valid;
  logic [DATA_W-1:0] peak_power;
  logic [IDX_W-1:0]  peak_bin;
  logic [IDX_W-1:0]  peak_fft_index;
  logic [IDX_W:0]    det_count;
  logic [SUM_W-1:0]  frame_sum;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] prev_pow;

  spectrum_peak_detector #(
    .BIN_NUM(BIN_NUM), .DATA_W(DATA_W), .IDX_W(IDX_W), .SUM_W(SUM_W)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .power_in(power_in),
    .fft_index_in(fft_index_in), .threshold(threshold), .peak_valid(peak_valid),
    .peak_power(peak_power), .peak_bin(peak_bin), .peak_fft_index(peak_fft_index),
    .det_count(det_count), .frame_sum(frame_sum), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Original FFT index of a shifted bin (shift stage drops a 192-bin gap).
  function automatic logic [IDX_W-1:0] fi(input int b);
    if (b < 4000) return IDX_W'(b + 4192);
    return IDX_W'(b - 4000);
  endfunction

  function automatic logic [DATA_W-1:0] pw(input int mode, input int b);
    case (mode)
      0:       return DATA_W'(b);
      1:       return (b == 100 || b == 200) ? DATA_W'(1000) : DATA_W'(5);
      2:       return 32'hFFFF_FFFF;
      3:       return (b == 5000) ? DATA_W'(9000) : DATA_W'(b % 100);
      default: return (b == 10) ? DATA_W'(50) : DATA_W'(3);
    endcase
  endfunction

  // Entered and left at a negedge; the last bin's report is checked at the
  // negedge right after its acceptance edge, so a following call is back-to-back.
  task automatic send_frame(input int mode, input logic [DATA_W-1:0] thr, input bit gapped,
                            input logic [DATA_W-1:0] e_pow, input int e_bin, input int e_det);
    int spurious = 0;
    logic [63:0] sum = 0;
    for (int b = 0; b < BIN_NUM; b++) begin
      valid_in     = 1'b1;
      power_in     = pw(mode, b);
      fft_index_in = fi(b);
      threshold    = thr;
      sum          = sum + 64'(pw(mode, b));
      @(negedge clk);
      if (peak_valid && b != BIN_NUM - 1) spurious++;
      if (b == 0) begin
        check_eq("held_report", 64'(peak_power), 64'(prev_pow));
        check_eq("busy_scan", 64'(busy), 64'd1);
      end
      if (gapped && b != BIN_NUM - 1) begin
        valid_in = 1'b0;
        @(negedge clk);
        if (peak_valid) spurious++;
      end
    end
    check_eq("peak_valid", 64'(peak_valid), 64'd1);
    check_eq("peak_power", 64'(peak_power), 64'(e_pow));
    check_eq("peak_bin", 64'(peak_bin), 64'(e_bin));
    check_eq("peak_fft_index", 64'(peak_fft_index), 64'(fi(e_bin)));
    check_eq("det_count", 64'(det_count), 64'(e_det));
`ifdef NOISE_SUM_EN
    check_eq("frame_sum", 64'(frame_sum), sum);
`else
    check_eq("frame_sum", 64'(frame_sum), 64'd0);
`endif
    check_eq("no_extra_pulse", 64'(spurious), 64'd0);
    prev_pow = e_pow;
  endtask

  task automatic idle_cycle();
    valid_in = 1'b0;
    @(negedge clk);
    check_eq("pulse_one_cycle", 64'(peak_valid), 64'd0);
    check_eq("busy_idle", 64'(busy), 64'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_valid"}, 64'(peak_valid), 64'd0);
    check_eq({tag, "_power"}, 64'(peak_power), 64'd0);
    check_eq({tag, "_bin"}, 64'(peak_bin), 64'd0);
    check_eq({tag, "_idx"}, 64'(peak_fft_index), 64'd0);
    check_eq({tag, "_det"}, 64'(det_count), 64'd0);
    check_eq({tag, "_sum"}, 64'(frame_sum), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst          = 1'b1;
    valid_in     = 1'b0;
    power_in     = '0;
    fft_index_in = '0;
    threshold    = '0;
    prev_pow     = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_eq("busy_after_reset", 64'(busy), 64'd0);

    // Ramp: peak at the last bin, bins 7991..7999 exceed 7990.
    send_frame(0, 32'd7990, 1'b0, 32'd7999, 7999, 9);
    idle_cycle();

    // Tie at 100/200 keeps bin 100; then frame of all-ones follows with no gap.
    send_frame(1, 32'hFFFF_FFFF, 1'b0, 32'd1000, 100, 0);
    send_frame(2, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFF, 0, BIN_NUM);
`ifdef NOISE_SUM_EN
    check_eq("sum_all_ones", 64'(frame_sum), 64'h1F3F_FFFF_E0C0);
`endif
    idle_cycle();

    // Two gapped frames: peak 9000 at bin 5000; 80 bins of 99 plus the peak exceed 98.
    send_frame(3, 32'd98, 1'b1, 32'd9000, 5000, 81);
    idle_cycle();
    send_frame(3, 32'd98, 1'b1, 32'd9000, 5000, 81);
    idle_cycle();

    // Reset in the middle of a frame; the following report covers only new bins.
    for (int b = 0; b < 4000; b++) begin
      valid_in     = 1'b1;
      power_in     = pw(0, b);
      fft_index_in = fi(b);
      threshold    = 32'd0;
      @(negedge clk);
    end
    rst      = 1'b1;
    valid_in = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_hold");
    rst      = 1'b0;
    prev_pow = '0;
    send_frame(4, 32'd3, 1'b0, 32'd50, 10, 1);
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
